lif_neuron_array: RTL and testbench
===================================

Name: lif_neuron_array

Overview:
- Parametrised successor to the single 8-bit leaky integrate-and-fire neuron.
- NCH independent LIF channels share one step strobe. Each channel has configurable width, shift-based leak, runtime threshold, saturating integration and a refractory period.
- Sits between the input-current source (switch bank or upstream layer) and the spike/membrane-state outputs.

Parameters:
- NCH, 4, number of neuron channels (>=1)
- WIDTH, 8, membrane potential and input current width, unsigned
- LEAK_SHIFT, 4, leak per step = V >> LEAK_SHIFT (1..WIDTH-1)
- REFRAC_STEPS, 2, steps held in refractory after a spike (0 = none)
- CNT_W, 8, spike counter width (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  step strobe; all channels advance one time step
- current  in  NCH*WIDTH  per-channel input current; channel i at [i*WIDTH +: WIDTH]
- thresh  in  WIDTH  firing threshold, shared by all channels, sampled on each step
- out_valid  out  1  pulses one cycle after each in_valid
- spike  out  NCH  one-cycle spike pulse per channel, aligned with out_valid
- state  out  NCH*WIDTH  membrane potential per channel (registered)
- spike_count  out  NCH*CNT_W  per-channel spike counts (exists only with LIF_SPIKE_COUNT_EN)

Behaviour:
- Reset (rst=1 at a clk edge): all state=0, spike=0, out_valid=0, every channel in INTEGRATE with refrac counter 0, counters 0. Reset overrides in_valid in the same cycle.
- in_valid=0: every register holds; spike=0; out_valid=0.
- Latency: one cycle. A step on cycle t produces spike/state/out_valid at t+1.
- Per-channel FSM, two states:
  - INTEGRATE:
    - Compute sum = V - (V>>LEAK_SHIFT) + I in WIDTH+1 bits.
    - Saturate the result to 2^WIDTH-1.
    - If the result >= thresh: spike=1, V<=0. Go to REFRACTORY with count=REFRAC_STEPS, or stay in INTEGRATE if REFRAC_STEPS=0.
    - Otherwise V<=result, spike=0.
  - REFRACTORY:
    - V held at 0; current ignored; spike=0.
    - count decrements on each step. On the step where count==1, go to INTEGRATE; current is still ignored on that step.
- thresh=0: every INTEGRATE step spikes.
- thresh changes take effect on the next step; no retroactive spike.
- Channels are fully independent. Simultaneous spikes on any subset are legal.
- Widths: the leak term never underflows, since V>>s <= V. Only the add can overflow, and it saturates.

Optional Feature:
- LIF_SPIKE_COUNT_EN defined:
  - Adds the spike_count port and one CNT_W counter per channel.
  - The counter increments in the same cycle its spike register is set, so spike_count is visible together with the spike.
  - Wraps modulo 2^CNT_W; cleared only by rst.
- Undefined: no port, no counter logic; behaviour otherwise identical.

Decomposition:
- Package lif_pkg:
  - channel state enum {INTEGRATE, REFRACTORY}
  - saturating-add function
  - default parameter constants
- Sub-module lif_core: one channel (FSM, leak, integrate, refrac counter, optional counter). lif_neuron_array instantiates NCH copies via generate and handles out_valid.

Test Plan (NCH=4, WIDTH=8, LEAK_SHIFT=4, REFRAC_STEPS=2 unless noted):
- Integrate-to-fire:
  - Stimulus: ch0 current 0x20 every step, thresh 0x80.
  - Required: state 32, 62, 91, 118; spike on step 5 with state 0.
  - Then steps 6-7 are refractory (state 0, no spike); integration resumes on step 8 with state 32.
- Saturation:
  - Stimulus: current 0xF0, thresh 0xFF.
  - Required: step 1 state 240; step 2 sum 465 saturates to 255 >= thresh, giving spike and state 0.
- Pure leak:
  - Stimulus: one step at current 0x80, then current 0, thresh 0xFF.
  - Required: state 128, 120, 113, 106, 100; never spikes.
- Hold and timing:
  - Stimulus: in_valid gaps of 3 cycles between steps.
  - Required: state and FSM frozen during gaps; out_valid and spike only on the cycle after each in_valid.
- Reset mid-refractory:
  - Stimulus: assert rst on the cycle after a spike.
  - Required: next cycle state 0, INTEGRATE; the first subsequent step integrates current immediately.
- Channel independence:
  - Stimulus: ch0-3 currents 0x80/0x40/0x00/0xFF, thresh 0x80.
  - Required: ch0 and ch3 spike on step 1, ch1 on step 3 (64, 124, 181), ch2 never.
  - With LIF_SPIKE_COUNT_EN: counts match the spike totals, and wrap is checked at CNT_W=2.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types, default parameters and the saturating adder for the LIF neuron array.
package lif_pkg;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } lif_state_e;

  localparam int DEF_NCH          = 4;
  localparam int DEF_WIDTH        = 8;
  localparam int DEF_LEAK_SHIFT   = 4;
  localparam int DEF_REFRAC_STEPS = 2;
  localparam int DEF_CNT_W        = 8;

  // Widest membrane supported by sat_add.
  localparam int MAX_W = 32;

  // Unsigned a + b clamped to 2^width - 1 (width <= MAX_W).
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int               width);
    logic [MAX_W:0] sum;
    logic [MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((MAX_W + 1)'(1) << width) - (MAX_W + 1)'(1);
    return (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/lif_neuron_array_core.sv
// One leaky integrate-and-fire channel: leak, saturating integrate, fire, refractory hold.
// Optional per-channel spike counter when LIF_SPIKE_COUNT_EN is defined.
module lif_core
  import lif_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int LEAK_SHIFT   = DEF_LEAK_SHIFT,
  parameter int REFRAC_STEPS = DEF_REFRAC_STEPS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [WIDTH-1:0] current,
  input  logic [WIDTH-1:0] thresh,
  output logic             spike,
  output logic [WIDTH-1:0] state
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [CNT_W-1:0] spike_count
`endif
);

  localparam int RC_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  if (LEAK_SHIFT < 1 || LEAK_SHIFT >= WIDTH) begin : g_bad_leak
    $error("lif_core: LEAK_SHIFT must be in 1..WIDTH-1");
  end
  if (WIDTH > MAX_W || CNT_W < 1) begin : g_bad_width
    $error("lif_core: WIDTH exceeds MAX_W or CNT_W < 1");
  end

  lif_state_e       fsm_q, fsm_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [WIDTH-1:0] v_d;
  logic             spike_d;
  logic [WIDTH-1:0] leaked;
  logic [WIDTH-1:0] integ;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    fsm_d   = fsm_q;
    rc_d    = rc_q;
    v_d     = state;
    spike_d = 1'b0;
    leaked  = state - (state >> LEAK_SHIFT);
    integ   = WIDTH'(sat_add(MAX_W'(leaked), MAX_W'(current), WIDTH));
    if (step) begin
      unique case (fsm_q)
        INTEGRATE: begin
          if (integ >= thresh) begin
            spike_d = 1'b1;
            v_d     = '0;
            if (REFRAC_STEPS > 0) begin
              fsm_d = REFRACTORY;
              rc_d  = RC_W'(REFRAC_STEPS);
            end
          end else begin
            v_d = integ;
          end
        end
        REFRACTORY: begin
          // Current is ignored on every refractory step, including the last.
          v_d  = '0;
          rc_d = rc_q - RC_W'(1);
          if (rc_q == RC_W'(1)) fsm_d = INTEGRATE;
        end
        default: fsm_d = INTEGRATE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= INTEGRATE;
      rc_q  <= '0;
      state <= '0;
      spike <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      rc_q  <= rc_d;
      state <= v_d;
      spike <= spike_d;
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  // Counts alongside the spike register so both become visible together.
  always_ff @(posedge clk) begin
    if (rst)          spike_count <= '0;
    else if (spike_d) spike_count <= spike_count + CNT_W'(1);
  end
`endif

endmodule

// File: rtl/lif_neuron_array.sv
// Array of NCH independent LIF channels sharing one step strobe; out_valid follows each step.
// Optional spike counters are enabled by defining LIF_SPIKE_COUNT_EN.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int NCH          = DEF_NCH,
  parameter int WIDTH        = DEF_WIDTH,
  parameter int LEAK_SHIFT   = DEF_LEAK_SHIFT,
  parameter int REFRAC_STEPS = DEF_REFRAC_STEPS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [NCH*WIDTH-1:0] current,
  input  logic [WIDTH-1:0]     thresh,
  output logic                 out_valid,
  output logic [NCH-1:0]       spike,
  output logic [NCH*WIDTH-1:0] state
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [NCH*CNT_W-1:0] spike_count
`endif
);

  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    lif_core #(
      .WIDTH       (WIDTH),
      .LEAK_SHIFT  (LEAK_SHIFT),
      .REFRAC_STEPS(REFRAC_STEPS),
      .CNT_W       (CNT_W)
    ) u_core (
      .clk        (clk),
      .rst        (rst),
      .step       (in_valid),
      .current    (current[i*WIDTH +: WIDTH]),
      .thresh     (thresh),
      .spike      (spike[i]),
      .state      (state[i*WIDTH +: WIDTH])
`ifdef LIF_SPIKE_COUNT_EN
      ,
      .spike_count(spike_count[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: directed steps push expectations, a monitor checks outputs.
module tb_lif_neuron_array;

  localparam int NCH   = 4;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic [NCH*WIDTH-1:0] current = '0;
  logic [WIDTH-1:0]     thresh = '0;
  logic                 out_valid;
  logic [NCH-1:0]       spike;
  logic [NCH*WIDTH-1:0] state;
`ifdef LIF_SPIKE_COUNT_EN
  logic [NCH*CNT_W-1:0] spike_count;
`endif

  lif_neuron_array #(
    .NCH         (NCH),
    .WIDTH       (WIDTH),
    .LEAK_SHIFT  (4),
    .REFRAC_STEPS(2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .current  (current),
    .thresh   (thresh),
    .out_valid(out_valid),
    .spike    (spike),
    .state    (state)
`ifdef LIF_SPIKE_COUNT_EN
    ,
    .spike_count(spike_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]       spike;
    logic [NCH*WIDTH-1:0] state;
    logic [NCH*CNT_W-1:0] cnt;
    int                   due;
    string                name;
  } exp_t;

  exp_t                 exp_q[$];
  int                   checks = 0;
  int                   failures = 0;
  int                   cyc = 0;
  logic [NCH*WIDTH-1:0] last_state = '0;
  logic [NCH*CNT_W-1:0] exp_cnt = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per out_valid; between steps outputs must stay frozen.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid) begin
        check("out_valid_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
          check({e.name, "_spike"}, 64'(spike), 64'(e.spike));
          check({e.name, "_state"}, 64'(state), 64'(e.state));
`ifdef LIF_SPIKE_COUNT_EN
          check({e.name, "_count"}, 64'(spike_count), 64'(e.cnt));
`endif
          last_state = e.state;
        end
      end else begin
        check("idle_hold", {31'd0, spike != '0, state}, {32'd0, last_state});
      end
    end
  end

  // One step: cur/est are packed {ch3,ch2,ch1,ch0}.
  task automatic do_step(input logic [NCH*WIDTH-1:0] cur, input logic [WIDTH-1:0] th,
                         input logic [NCH-1:0] esp, input logic [NCH*WIDTH-1:0] est,
                         input string name);
    exp_t e;
    for (int i = 0; i < NCH; i++)
      if (esp[i]) exp_cnt[i*CNT_W +: CNT_W] = exp_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
    e.spike = esp;
    e.state = est;
    e.cnt   = exp_cnt;
    e.due   = cyc + 1;
    e.name  = name;
    exp_q.push_back(e);
    current  = cur;
    thresh   = th;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One idle cycle lets the monitor drain, then a single-cycle reset.
  task automatic do_reset();
    idle(1);
    rst      = 1'b1;
    in_valid = 1'b1;
    current  = '1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    in_valid   = 1'b0;
    current    = '0;
    last_state = '0;
    exp_cnt    = '0;
    check("reset_outputs", {30'd0, out_valid, spike != '0, state}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Integrate to fire on ch0, then two refractory steps, then integration resumes.
    do_step(32'h00000020, 8'h80, 4'b0000, 32'h00000020, "itf1");
    do_step(32'h00000020, 8'h80, 4'b0000, 32'h0000003E, "itf2");
    do_step(32'h00000020, 8'h80, 4'b0000, 32'h0000005B, "itf3");
    do_step(32'h00000020, 8'h80, 4'b0000, 32'h00000076, "itf4");
    do_step(32'h00000020, 8'h80, 4'b0001, 32'h00000000, "itf5");
    do_step(32'h00000020, 8'h80, 4'b0000, 32'h00000000, "itf6");
    do_step(32'h00000020, 8'h80, 4'b0000, 32'h00000000, "itf7");
    do_step(32'h00000020, 8'h80, 4'b0000, 32'h00000020, "itf8");

    // Saturation: 240 - 15 + 240 clamps to 255, which meets thresh 255.
    do_reset();
    do_step(32'h000000F0, 8'hFF, 4'b0000, 32'h000000F0, "sat1");
    do_step(32'h000000F0, 8'hFF, 4'b0001, 32'h00000000, "sat2");

    // Pure leak, then steps separated by 3-cycle gaps.
    do_reset();
    do_step(32'h00000080, 8'hFF, 4'b0000, 32'h00000080, "leak1");
    do_step(32'h00000000, 8'hFF, 4'b0000, 32'h00000078, "leak2");
    do_step(32'h00000000, 8'hFF, 4'b0000, 32'h00000071, "leak3");
    do_step(32'h00000000, 8'hFF, 4'b0000, 32'h0000006A, "leak4");
    do_step(32'h00000000, 8'hFF, 4'b0000, 32'h00000064, "leak5");
    idle(3);
    do_step(32'h00000000, 8'hFF, 4'b0000, 32'h0000005E, "gap1");
    idle(3);
    do_step(32'h00000000, 8'hFF, 4'b0000, 32'h00000059, "gap2");
    idle(3);

    // Channel independence: ch0 0x80, ch1 0x40, ch2 0x00, ch3 0xFF, thresh 0x80.
    do_reset();
    do_step(32'hFF004080, 8'h80, 4'b1001, 32'h00004000, "ind1");
    do_step(32'hFF004080, 8'h80, 4'b0000, 32'h00007C00, "ind2");
    do_step(32'hFF004080, 8'h80, 4'b0010, 32'h00000000, "ind3");
    do_step(32'hFF004080, 8'h80, 4'b1001, 32'h00000000, "ind4");
    do_step(32'hFF004080, 8'h80, 4'b0000, 32'h00000000, "ind5");
    do_step(32'hFF004080, 8'h80, 4'b0000, 32'h00004000, "ind6");
    do_step(32'hFF004080, 8'h80, 4'b1001, 32'h00007C00, "ind7");
    do_step(32'hFF004080, 8'h80, 4'b0010, 32'h00000000, "ind8");
    do_step(32'hFF004080, 8'h80, 4'b0000, 32'h00000000, "ind9");
    do_step(32'hFF004080, 8'h80, 4'b1001, 32'h00000000, "ind10");

    // thresh 0 fires every integrating channel even with zero current.
    do_reset();
    do_step(32'h00000000, 8'h00, 4'b1111, 32'h00000000, "th0");

    // Reset mid-refractory: the next step integrates immediately.
    do_reset();
    do_step(32'h00000080, 8'h80, 4'b0001, 32'h00000000, "rmr_fire");
    do_reset();
    do_step(32'h00000020, 8'h80, 4'b0000, 32'h00000020, "rmr_after");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
